d3s_lut_loader: RTL and testbench

Bank-switching load controller for the D3S DAC waveform LUT. The host fills the inactive (shadow) bank of a two-bank sample/slope LUT through a write port with an auto-incrementing address. A commit swaps the banks only on a datapath sync strobe, so the phase-to-sample lookup never reads a half-written table. It sits between the host config registers and the LUT memories that feed the phase-to-DAC lookup stage.

---
 rtl/d3s_lut_pkg.sv | 22 ++
 rtl/d3s_lut_loader.sv | 138 +++++++++++++
 tb/tb_d3s_lut_loader.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/d3s_lut_pkg.sv
// Shared types and default geometry for the D3S waveform LUT bank loader.
package d3s_lut_pkg;

    localparam int unsigned LUT_SIZE_LOG2_DEF = 10;
    localparam int unsigned SAMPLE_BITS_DEF   = 18;
    localparam int unsigned SLOPE_BITS_DEF    = 18;

    // An entry packs {slope, sample} with the sample in the LSBs.
    function automatic int unsigned entry_bits(input int unsigned sample_bits,
                                               input int unsigned slope_bits);
        return sample_bits + slope_bits;
    endfunction

    localparam int unsigned ENTRY_BITS_DEF = entry_bits(SAMPLE_BITS_DEF, SLOPE_BITS_DEF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_ARMED = 2'd2
    } lut_state_e;

endpackage

// File: rtl/d3s_lut_loader.sv
// Two-bank LUT load controller: host fills the shadow bank, banks swap only on
// a datapath sync strobe after commit.
module d3s_lut_loader
    import d3s_lut_pkg::*;
#(
    parameter int unsigned g_lut_size_log2   = LUT_SIZE_LOG2_DEF,
    parameter int unsigned g_lut_sample_bits = SAMPLE_BITS_DEF,
    parameter int unsigned g_lut_slope_bits  = SLOPE_BITS_DEF
) (
    input  logic                                              clk_i,
    input  logic                                              rst_n_i,
    input  logic [g_lut_size_log2-1:0]                        cfg_addr_i,
    input  logic                                              cfg_addr_load_i,
    input  logic [g_lut_sample_bits+g_lut_slope_bits-1:0]     cfg_data_i,
    input  logic                                              cfg_wr_i,
    input  logic                                              cfg_clear_i,
    input  logic                                              cfg_commit_i,
    input  logic                                              cfg_abort_i,
    input  logic                                              sync_i,
    output logic                                              cfg_busy_o,
    output logic                                              cfg_err_o,
    output logic                                              swap_done_o,
    output logic [g_lut_size_log2-1:0]                        wr_ptr_o,
    output logic                                              active_bank_o,
    output logic                                              lut_we_o,
    output logic                                              lut_bank_o,
    output logic [g_lut_size_log2-1:0]                        lut_addr_o,
    output logic [g_lut_sample_bits+g_lut_slope_bits-1:0]     lut_data_o
);

    localparam int unsigned AW = g_lut_size_log2;
    localparam int unsigned W  = entry_bits(g_lut_sample_bits, g_lut_slope_bits);

    lut_state_e       state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic             active_q, active_d;
    logic             busy_d, err_d, swap_d, we_d;
    logic [AW-1:0]    addr_d;
    logic [W-1:0]     data_d;
    logic             cmd_any;

    assign cmd_any = cfg_clear_i | cfg_commit_i | cfg_addr_load_i | cfg_wr_i;

    // State, shared pointer/clear counter and all registered outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            active_q      <= 1'b0;
            cfg_busy_o    <= 1'b0;
            cfg_err_o     <= 1'b0;
            swap_done_o   <= 1'b0;
            lut_we_o      <= 1'b0;
            lut_bank_o    <= 1'b1;
            lut_addr_o    <= '0;
            lut_data_o    <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            active_q      <= active_d;
            cfg_busy_o    <= busy_d;
            cfg_err_o     <= err_d;
            swap_done_o   <= swap_d;
            lut_we_o      <= we_d;
            lut_bank_o    <= ~active_d;
            lut_addr_o    <= addr_d;
            lut_data_o    <= data_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        active_d = active_q;
        err_d    = 1'b0;
        swap_d   = 1'b0;
        we_d     = 1'b0;
        addr_d   = lut_addr_o;
        data_d   = lut_data_o;

        unique case (state_q)
            ST_IDLE: begin
                if (cfg_clear_i) begin
                    state_d = ST_CLEAR;
                    err_d   = cfg_commit_i | cfg_addr_load_i | cfg_wr_i;
                    we_d    = 1'b1;
                    addr_d  = '0;
                    data_d  = '0;
                    ptr_d   = AW'(1);
                end else if (cfg_commit_i) begin
                    state_d = ST_ARMED;
                    err_d   = cfg_addr_load_i | cfg_wr_i;
                end else if (cfg_addr_load_i) begin
                    ptr_d   = cfg_addr_i;
                    err_d   = cfg_wr_i;
                end else if (cfg_wr_i) begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    data_d  = cfg_data_i;
                    ptr_d   = ptr_q + AW'(1);
                end
            end
            // Pointer holds the next address; wrapping to 0 means all N were issued
            ST_CLEAR: begin
                err_d = cmd_any;
                if (ptr_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    we_d   = 1'b1;
                    addr_d = ptr_q;
                    data_d = '0;
                    ptr_d  = ptr_q + AW'(1);
                end
            end
            ST_ARMED: begin
                err_d = cmd_any;
                if (sync_i) begin
                    state_d  = ST_IDLE;
                    active_d = ~active_q;
                    swap_d   = 1'b1;
                    ptr_d    = '0;
                end else if (cfg_abort_i) begin
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign wr_ptr_o      = ptr_q;
    assign active_bank_o = active_q;

endmodule

// File: tb/tb_d3s_lut_loader.sv
// Randomized bench for d3s_lut_loader against a transaction-level reference model.
module tb_d3s_lut_loader;

    localparam int unsigned AW = 10;
    localparam int unsigned W  = 36;
    localparam int          N  = 1024;

    logic            clk_i = 1'b0;
    logic            rst_n_i;
    logic [AW-1:0]   cfg_addr_i;
    logic            cfg_addr_load_i;
    logic [W-1:0]    cfg_data_i;
    logic            cfg_wr_i, cfg_clear_i, cfg_commit_i, cfg_abort_i, sync_i;
    logic            cfg_busy_o, cfg_err_o, swap_done_o, active_bank_o;
    logic            lut_we_o, lut_bank_o;
    logic [AW-1:0]   wr_ptr_o, lut_addr_o;
    logic [W-1:0]    lut_data_o;

    always #5 clk_i = ~clk_i;

    d3s_lut_loader dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .cfg_addr_i(cfg_addr_i), .cfg_addr_load_i(cfg_addr_load_i),
        .cfg_data_i(cfg_data_i), .cfg_wr_i(cfg_wr_i), .cfg_clear_i(cfg_clear_i),
        .cfg_commit_i(cfg_commit_i), .cfg_abort_i(cfg_abort_i), .sync_i(sync_i),
        .cfg_busy_o(cfg_busy_o), .cfg_err_o(cfg_err_o), .swap_done_o(swap_done_o),
        .wr_ptr_o(wr_ptr_o), .active_bank_o(active_bank_o), .lut_we_o(lut_we_o),
        .lut_bank_o(lut_bank_o), .lut_addr_o(lut_addr_o), .lut_data_o(lut_data_o)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: clear progress as an address index, armed as a flag
    int           m_ptr, m_active, m_clear_idx;
    bit           m_armed;
    bit           e_we, e_err, e_swap, e_busy;
    int           e_addr;
    logic [W-1:0] e_data;
    int           n_we_seen, n_err_seen, n_swap_seen, n_busy_seen;

    task automatic model_reset();
        m_ptr = 0; m_active = 0; m_clear_idx = -1; m_armed = 0;
        e_we = 0; e_err = 0; e_swap = 0; e_busy = 0; e_addr = 0; e_data = '0;
    endtask

    task automatic model_step();
        int ncmd;
        ncmd = int'(cfg_clear_i) + int'(cfg_commit_i) + int'(cfg_addr_load_i) + int'(cfg_wr_i);
        e_we = 0; e_err = 0; e_swap = 0;
        if (m_clear_idx >= 0) begin
            e_err = (ncmd > 0);
            if (m_clear_idx < N - 1) begin
                m_clear_idx++;
                e_we = 1; e_addr = m_clear_idx; e_data = '0;
            end else begin
                m_clear_idx = -1;
                m_ptr = 0;
            end
        end else if (m_armed) begin
            e_err = (ncmd > 0);
            if (sync_i) begin
                m_active = 1 - m_active;
                e_swap = 1; m_ptr = 0; m_armed = 0;
            end else if (cfg_abort_i) begin
                m_armed = 0;
            end
        end else begin
            e_err = (ncmd > 1);
            if (cfg_clear_i) begin
                m_clear_idx = 0;
                e_we = 1; e_addr = 0; e_data = '0;
            end else if (cfg_commit_i) begin
                m_armed = 1;
            end else if (cfg_addr_load_i) begin
                m_ptr = int'(cfg_addr_i);
            end else if (cfg_wr_i) begin
                e_we = 1; e_addr = m_ptr; e_data = cfg_data_i;
                m_ptr = (m_ptr + 1) % N;
            end
        end
        e_busy = (m_clear_idx >= 0) || m_armed;
    endtask

    task automatic idle_inputs();
        cfg_addr_load_i = 0; cfg_wr_i = 0; cfg_clear_i = 0;
        cfg_commit_i = 0; cfg_abort_i = 0; sync_i = 0;
    endtask

    // One clock: advance model, sample DUT 1 time unit after the edge, drop commands
    task automatic tick();
        model_step();
        @(posedge clk_i);
        #1;
        chk("we", 64'(lut_we_o), 64'(e_we));
        chk("active_bank", 64'(active_bank_o), 64'(m_active));
        chk("lut_bank", 64'(lut_bank_o), 64'(1 - m_active));
        chk("busy", 64'(cfg_busy_o), 64'(e_busy));
        chk("err", 64'(cfg_err_o), 64'(e_err));
        chk("swap_done", 64'(swap_done_o), 64'(e_swap));
        if (m_clear_idx < 0) chk("wr_ptr", 64'(wr_ptr_o), 64'(m_ptr));
        if (e_we) begin
            chk("lut_addr", 64'(lut_addr_o), 64'(e_addr));
            chk("lut_data", 64'(lut_data_o), 64'(e_data));
        end
        n_we_seen   += int'(lut_we_o);
        n_err_seen  += int'(cfg_err_o);
        n_swap_seen += int'(swap_done_o);
        n_busy_seen += int'(cfg_busy_o);
        idle_inputs();
    endtask

    task automatic write(input logic [W-1:0] d);
        cfg_wr_i = 1; cfg_data_i = d; tick();
    endtask

    task automatic clear_counters();
        n_we_seen = 0; n_err_seen = 0; n_swap_seen = 0; n_busy_seen = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        cfg_addr_i = '0; cfg_data_i = '0;
        rst_n_i = 0;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_active", 64'(active_bank_o), 64'(0));
        chk("rst_lut_bank", 64'(lut_bank_o), 64'(1));
        chk("rst_ptr", 64'(wr_ptr_o), 64'(0));
        chk("rst_busy", 64'(cfg_busy_o), 64'(0));
        chk("rst_we", 64'(lut_we_o), 64'(0));
        rst_n_i = 1;
        tick();

        // Pointer load near the top, writes wrap past N-1
        cfg_addr_load_i = 1; cfg_addr_i = AW'(10'h3FE); tick();
        write(36'hA_AAAA_0001);
        chk("p1_addr0", 64'(lut_addr_o), 64'(10'h3FE));
        write(36'hB_BBBB_0002);
        chk("p1_addr1", 64'(lut_addr_o), 64'(10'h3FF));
        write(36'hC_CCCC_0003);
        chk("p1_addr2", 64'(lut_addr_o), 64'(0));
        chk("p1_bank", 64'(lut_bank_o), 64'(1));
        chk("p1_ptr", 64'(wr_ptr_o), 64'(1));
        tick();

        // Commit then sync five cycles later
        clear_counters();
        cfg_commit_i = 1; tick();
        repeat (4) tick();
        sync_i = 1; tick();
        chk("p2_busy_cycles", 64'(n_busy_seen), 64'(5));
        chk("p2_active", 64'(active_bank_o), 64'(1));
        chk("p2_swaps", 64'(n_swap_seen), 64'(1));
        tick();
        write(36'h1_2345_6789);
        chk("p2_wr_bank", 64'(lut_bank_o), 64'(0));
        chk("p2_wr_addr", 64'(lut_addr_o), 64'(0));

        // Sync in the commit cycle must not swap
        clear_counters();
        cfg_commit_i = 1; sync_i = 1; tick();
        chk("p3_no_early_swap", 64'(active_bank_o), 64'(1));
        repeat (2) tick();
        sync_i = 1; tick();
        chk("p3_active", 64'(active_bank_o), 64'(0));
        chk("p3_swaps", 64'(n_swap_seen), 64'(1));
        tick();

        // Clear with a write dropped at cycle 10
        clear_counters();
        cfg_clear_i = 1; tick();
        for (int k = 1; k < 2000 && cfg_busy_o; k++) begin
            if (k == 10) begin cfg_wr_i = 1; cfg_data_i = 36'hF_FFFF_FFFF; end
            tick();
        end
        chk("p4_clear_writes", 64'(n_we_seen), 64'(N));
        chk("p4_clear_err", 64'(n_err_seen), 64'(1));
        chk("p4_ptr_after", 64'(wr_ptr_o), 64'(0));

        // Abort without sync, then abort racing a sync
        clear_counters();
        cfg_commit_i = 1; tick();
        cfg_abort_i = 1; tick();
        sync_i = 1; tick();
        chk("p5_abort_active", 64'(active_bank_o), 64'(0));
        chk("p5_abort_swaps", 64'(n_swap_seen), 64'(0));
        cfg_commit_i = 1; tick();
        tick();
        cfg_abort_i = 1; sync_i = 1; tick();
        chk("p5_race_active", 64'(active_bank_o), 64'(1));
        chk("p5_race_swaps", 64'(n_swap_seen), 64'(1));
        tick();

        // Asynchronous reset in the middle of a clear
        cfg_clear_i = 1; tick();
        repeat (499) tick();
        chk("p6_clearing", 64'(lut_we_o), 64'(1));
        #2;
        rst_n_i = 0;
        #1;
        model_reset();
        chk("p6_we_async", 64'(lut_we_o), 64'(0));
        chk("p6_active", 64'(active_bank_o), 64'(0));
        chk("p6_busy", 64'(cfg_busy_o), 64'(0));
        chk("p6_ptr", 64'(wr_ptr_o), 64'(0));
        chk("p6_lut_bank", 64'(lut_bank_o), 64'(1));
        @(posedge clk_i);
        #1;
        rst_n_i = 1;
        tick();

        // Randomized command mix with collisions
        for (int i = 0; i < 6000; i++) begin
            cfg_wr_i        = ($urandom_range(0, 2) == 0);
            cfg_addr_load_i = ($urandom_range(0, 19) == 0);
            cfg_commit_i    = ($urandom_range(0, 39) == 0);
            cfg_clear_i     = ($urandom_range(0, 1499) == 0);
            cfg_abort_i     = ($urandom_range(0, 29) == 0);
            sync_i          = ($urandom_range(0, 9) == 0);
            cfg_addr_i      = AW'($urandom);
            cfg_data_i      = {4'($urandom), $urandom};
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
